// File: rtl/bit32div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package bit32div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_STEPS);
    localparam int CLA_GROUP = 4;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/bit32div_sub.sv
// Combinational 32-bit subtractor: a + ~b + 1 through 4-bit carry-lookahead
// groups, with a group-level carry chain between them.
module bit32sub
    import bit32div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] a,
    input  logic [DIV_WIDTH-1:0] b,
    output logic [DIV_WIDTH-1:0] diff,
    output logic                 no_borrow
);

    localparam int NGRP = DIV_WIDTH / CLA_GROUP;

    logic [DIV_WIDTH-1:0] bn;
    logic [DIV_WIDTH-1:0] g;
    logic [DIV_WIDTH-1:0] p;
    logic [DIV_WIDTH:0]   c;
    logic [NGRP-1:0]      gg;
    logic [NGRP-1:0]      gp;

    always_comb begin
        bn   = ~b;
        g    = a & bn;
        p    = a ^ bn;
        c    = '0;
        gg   = '0;
        gp   = '0;
        c[0] = 1'b1;
        for (int k = 0; k < NGRP; k++) begin
            // carries inside a group depend only on the group carry-in
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            gg[k]    = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k]    = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
        end
        diff      = p ^ c[DIV_WIDTH-1:0];
        no_borrow = c[DIV_WIDTH];
    end

endmodule

// File: rtl/bit32div.sv
// Iterative unsigned divider, one restoring step per clock, valid/ready on both sides.
//   state  | meaning
//   S_IDLE | ready for operands
//   S_CALC | 32 restoring steps in progress
//   S_DONE | result held until out_ready
module bit32div
    import bit32div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_STEPS - 1);
    localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);

    div_state_t state, state_nxt;

    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     d_q;
    logic [DIV_CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] s;
    logic             no_borrow;
    logic             step_ok;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last_step;
    logic             accept;
    logic             zero_div;

    assign t         = {r_q, q_q[WIDTH-1]};
    assign step_ok   = t[WIDTH] | no_borrow;
    assign r_nxt     = step_ok ? s : t[WIDTH-1:0];
    assign q_nxt     = {q_q[WIDTH-2:0], step_ok};
    assign last_step = (cnt_q == CNT_LAST);
    assign accept    = (state == S_IDLE) && in_valid;
    assign zero_div  = (divisor == '0);

    bit32sub u_sub (
        .a         (t[WIDTH-1:0]),
        .b         (d_q),
        .diff      (s),
        .no_borrow (no_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = zero_div ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            d_q   <= divisor;
            q_q   <= dividend;
            r_q   <= '0;
            cnt_q <= '0;
            // a zero divisor skips CALC, so its result is published at acceptance
            if (zero_div) begin
                quotient    <= DIV_ZERO_QUOT;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == S_CALC) begin
            r_q   <= r_nxt;
            q_q   <= q_nxt;
            cnt_q <= cnt_q + CNT_ONE;
            if (last_step) begin
                quotient    <= q_nxt;
                remainder   <= r_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
